// File: rtl/alu_pkg.sv
// Shared opcode and arbiter state definitions for the ALU arbiter slice.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_INC = 4'd3,
        OP_DEC = 4'd4,
        OP_NOT = 4'd5,
        OP_SUB = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } alu_op_e;

    localparam logic [3:0] OP_LAST = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_e;

endpackage

// File: rtl/ALUparam.sv
// Parameterised combinational ALU: ten ops, result plus {zero, carry/shift-out} flags.
module ALUparam
    import alu_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [3:0]   ALUcontrol,
    input  logic         ALUFLAGin,
    output logic [n-1:0] ALUresult,
    output logic [1:0]   ALUflags
);

    logic [n-1:0] res;
    logic         cy;

    // cy is carry-out for ADD/INC/SHL/SHR and borrow for DEC/SUB; 0 for logic ops
    always_comb begin
        res = '0;
        cy  = 1'b0;
        case (ALUcontrol)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_ADD: {cy, res} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, ALUFLAGin};
            OP_INC: {cy, res} = {1'b0, a} + {{n{1'b0}}, 1'b1};
            OP_DEC: {cy, res} = {1'b0, a} - {{n{1'b0}}, 1'b1};
            OP_NOT: res = ALUFLAGin ? ~b : ~a;
            OP_SUB: {cy, res} = {1'b0, a} - {1'b0, b} - {{n{1'b0}}, ALUFLAGin};
            OP_XOR: res = a ^ b;
            OP_SHL: {cy, res} = {a, ALUFLAGin};
            OP_SHR: begin
                res = {ALUFLAGin, a[n-1:1]};
                cy  = a[0];
            end
            default: begin
                res = '0;
                cy  = 1'b0;
            end
        endcase
    end

    assign ALUresult = res;
    assign ALUflags  = {(res == '0), cy};

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALUparam between NREQ valid/ready requesters,
// returning result/flags/id on a held response channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int n    = 4,
    parameter  int NREQ = 2,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*n-1:0]   req_a,
    input  logic [NREQ*n-1:0]   req_b,
    input  logic [NREQ*4-1:0]   req_op,
    input  logic [NREQ-1:0]     req_fin,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [n-1:0]        rsp_result,
    output logic [1:0]          rsp_flags,
    output logic                rsp_err
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [n-1:0]    a_q, a_d;
    logic [n-1:0]    b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic            fin_q, fin_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [n-1:0]    rsp_result_q, rsp_result_d;
    logic [1:0]      rsp_flags_q, rsp_flags_d;
    logic            rsp_err_q, rsp_err_d;

    logic [n-1:0]    alu_result;
    logic [1:0]      alu_flags;
    logic [ID_W-1:0] grant_id;
    logic            any_valid;

    // Visit candidates from lowest to highest priority so the last hit,
    // i.e. the first valid one after `last`, is the one kept.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                                input logic [ID_W-1:0] last);
        logic [ID_W-1:0] sel;
        int unsigned     idx;
        sel = last;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(last) + NREQ - k) % NREQ;
            if (v[idx]) sel = ID_W'(idx);
        end
        return sel;
    endfunction

    assign any_valid = |req_valid;
    assign grant_id  = rr_pick(req_valid, last_q);

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && any_valid) req_ready[grant_id] = 1'b1;
    end

    ALUparam #(.n(n)) u_alu (
        .a          (a_q),
        .b          (b_q),
        .ALUcontrol (op_q),
        .ALUFLAGin  (fin_q),
        .ALUresult  (alu_result),
        .ALUflags   (alu_flags)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        fin_d        = fin_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    a_d     = req_a[grant_id*n +: n];
                    b_d     = req_b[grant_id*n +: n];
                    op_d    = req_op[grant_id*4 +: 4];
                    fin_d   = req_fin[grant_id];
                    id_d    = grant_id;
                    last_d  = grant_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                if (op_q > OP_LAST) begin
                    rsp_result_d = '0;
                    rsp_flags_d  = '0;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_err_d    = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= ID_W'(NREQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            fin_q        <= 1'b0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            fin_q        <= fin_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

endmodule
